// File: rtl/fetch_byte_queue.sv
// Instruction-byte queue: 8-byte fetch beats in, a zero-masked 15-byte decode
// window out, advanced by the decoder's reported instruction length.
module fetch_byte_queue #(
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [63:0]                flush_pc,
    input  logic                       fill_valid,
    input  logic [63:0]                fill_data,
    output logic                       fill_ready,
    output logic [0:119]               window,
    output logic                       window_valid,
    output logic [63:0]                window_pc,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       consume_valid,
    input  logic [3:0]                 consume_len,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH - 8);
    localparam logic [CW-1:0] WIN_MIN  = CW'(15);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head;
    logic [63:0]   pc;

    logic          fill_acc;
    logic          cons_acc;
    logic [AW-1:0] wr_base;
    logic [CW-1:0] count_next;

    // Status is a pure function of registered state, so the decoder never
    // sees a combinational path from its own consume inputs.
    assign fill_ready   = (count <= FILL_MAX);
    assign window_valid = (count >= WIN_MIN);
    assign window_pc    = pc;

    // A flush in the same cycle drops the fill beat and the consume.
    assign fill_acc = fill_valid & fill_ready & ~flush;
    assign cons_acc = consume_valid & window_valid & ~flush;

    // Beats land after the last buffered byte, measured before this cycle's consume.
    assign wr_base  = head + count[AW-1:0];

    always_comb begin
        count_next = count;
        if (fill_acc)
            count_next = count_next + CW'(8);
        if (cons_acc)
            count_next = count_next - CW'(consume_len);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            count     <= '0;
            pc        <= '0;
            underflow <= 1'b0;
        end else if (flush) begin
            head      <= '0;
            count     <= '0;
            pc        <= flush_pc;
            underflow <= 1'b0;
        end else begin
            count <= count_next;
            if (cons_acc) begin
                head <= head + AW'(consume_len);
                pc   <= pc + 64'(consume_len);
            end
            if (consume_valid && !window_valid)
                underflow <= 1'b1;
        end
    end

    // Byte storage carries no reset; unwritten bytes are masked out of the window.
    always_ff @(posedge clk) begin
        if (fill_acc) begin
            for (int i = 0; i < 8; i++)
                mem[wr_base + AW'(i)] <= fill_data[8*i +: 8];
        end
    end

    always_comb begin
        window = '0;
        for (int k = 0; k < 15; k++) begin
            if (CW'(k) < count)
                window[8*k +: 8] = mem[head + AW'(k)];
        end
    end

endmodule
